vend_controller: RTL and testbench

Transaction controller for the vending machine: consumes single-cycle coin, buy and cancel ticks from the front-panel edge detectors, and maintains the customer's credit. It tracks per-product stock, sequences the dispense strobe, and pays out change one coin per cycle. It sits between the input conditioning (edge detectors) and the actuator/display drivers.

---
 rtl/vend_pkg.sv | 33 +++
 rtl/vend_change_unit.sv | 26 ++
 rtl/vend_controller.sv | 186 ++++++++++++++++++
 tb/tb_vend_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCredit,
        StVend,
        StChange
    } state_e;

    localparam int unsigned CREDIT_W = 8;
    localparam int unsigned COIN_5   = 5;
    localparam int unsigned COIN_10  = 10;
    localparam int unsigned COIN_25  = 25;

    function automatic logic [CREDIT_W-1:0] price_of(
        input logic [1:0]  sel,
        input int unsigned p0,
        input int unsigned p1,
        input int unsigned p2,
        input int unsigned p3
    );
        logic [CREDIT_W-1:0] price;
        unique case (sel)
            2'd0: price = CREDIT_W'(p0);
            2'd1: price = CREDIT_W'(p1);
            2'd2: price = CREDIT_W'(p2);
            default: price = CREDIT_W'(p3);
        endcase
        return price;
    endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Greedy change selector: picks the largest coin not exceeding the credit.
module vend_change_unit
    import vend_pkg::*;
(
    input  logic [CREDIT_W-1:0] credit,
    output logic [2:0]          coin_sel,
    output logic [CREDIT_W-1:0] dec
);

    // coin_sel is one-hot {25, 10, 5}; all-zero when there is nothing to return
    always_comb begin
        coin_sel = 3'b000;
        dec      = '0;
        if (credit >= CREDIT_W'(COIN_25)) begin
            coin_sel = 3'b100;
            dec      = CREDIT_W'(COIN_25);
        end else if (credit >= CREDIT_W'(COIN_10)) begin
            coin_sel = 3'b010;
            dec      = CREDIT_W'(COIN_10);
        end else if (credit != '0) begin
            coin_sel = 3'b001;
            dec      = CREDIT_W'(COIN_5);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: credit, stock, dispense sequencing and change payout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned P0              = 25,
    parameter int unsigned P1              = 40,
    parameter int unsigned P2              = 65,
    parameter int unsigned P3              = 100,
    parameter int unsigned MAX_CREDIT      = 100,
    parameter int unsigned DISPENSE_CYCLES = 4,
    parameter int unsigned STOCK_INIT      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                coin_25,
    input  logic                buy,
    input  logic [1:0]          sel,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [1:0]          disp_sel,
    output logic                change_5,
    output logic                change_10,
    output logic                change_25,
    output logic                coin_reject,
    output logic                err_funds,
    output logic                err_sold,
    output logic [3:0]          sold_out,
    output logic                busy
);

    localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [3:0]          stock_q [4];
    logic [3:0]          stock_d [4];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dispense_q, dispense_d;
    logic [1:0]          disp_sel_q, disp_sel_d;
    logic [2:0]          change_q, change_d;
    logic                reject_q, reject_d;
    logic                funds_q, funds_d;
    logic                sold_q, sold_d;
    logic [3:0]          sold_out_q, sold_out_d;
    logic                busy_q, busy_d;

    logic [2:0]          eject_sel;
    logic [CREDIT_W-1:0] eject_dec;
    logic [CREDIT_W:0]   coin_sum, sum_total;
    logic [CREDIT_W-1:0] price;
    logic                any_coin, take_coins, do_eject;

    vend_change_unit u_change (
        .credit   (credit_q),
        .coin_sel (eject_sel),
        .dec      (eject_dec)
    );

    always_comb begin
        coin_sum = (coin_5  ? (CREDIT_W+1)'(COIN_5)  : '0)
                 + (coin_10 ? (CREDIT_W+1)'(COIN_10) : '0)
                 + (coin_25 ? (CREDIT_W+1)'(COIN_25) : '0);
        sum_total = {1'b0, credit_q} + coin_sum;
        price     = price_of(sel, P0, P1, P2, P3);
        any_coin  = coin_5 | coin_10 | coin_25;

        state_d    = state_q;
        credit_d   = credit_q;
        stock_d    = stock_q;
        cnt_d      = cnt_q;
        dispense_d = 1'b0;
        disp_sel_d = disp_sel_q;
        change_d   = 3'b000;
        reject_d   = 1'b0;
        funds_d    = 1'b0;
        sold_d     = 1'b0;
        take_coins = 1'b0;
        do_eject   = 1'b0;

        unique case (state_q)
            StIdle, StCredit: begin
                if (cancel) begin
                    reject_d = any_coin;
                    do_eject = (state_q == StCredit);
                end else if (buy && sold_out_q[sel]) begin
                    sold_d     = 1'b1;
                    take_coins = 1'b1;
                end else if (buy && (credit_q < price)) begin
                    funds_d    = 1'b1;
                    take_coins = 1'b1;
                end else if (buy) begin
                    reject_d     = any_coin;
                    credit_d     = credit_q - price;
                    stock_d[sel] = stock_q[sel] - 4'd1;
                    disp_sel_d   = sel;
                    cnt_d        = CNT_W'(DISPENSE_CYCLES - 1);
                    dispense_d   = 1'b1;
                    state_d      = StVend;
                end else begin
                    take_coins = 1'b1;
                end
            end
            StVend: begin
                reject_d = any_coin;
                if (cnt_q == '0) begin
                    if (credit_q != '0) do_eject = 1'b1;
                    else state_d = StIdle;
                end else begin
                    cnt_d      = cnt_q - 1'b1;
                    dispense_d = 1'b1;
                end
            end
            StChange: begin
                reject_d = any_coin;
                if (credit_q != '0) do_eject = 1'b1;
                else state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The whole cycle's coins are refused together when the ceiling would be exceeded
        if (take_coins && any_coin) begin
            if (sum_total > (CREDIT_W+1)'(MAX_CREDIT)) begin
                reject_d = 1'b1;
            end else begin
                credit_d = sum_total[CREDIT_W-1:0];
                state_d  = StCredit;
            end
        end

        if (do_eject) begin
            change_d = eject_sel;
            credit_d = credit_q - eject_dec;
            state_d  = (credit_q == eject_dec) ? StIdle : StChange;
        end

        for (int i = 0; i < 4; i++) sold_out_d[i] = (stock_d[i] == 4'd0);
        busy_d = (state_d == StVend) || (state_d == StChange);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            credit_q   <= '0;
            for (int i = 0; i < 4; i++) stock_q[i] <= 4'(STOCK_INIT);
            cnt_q      <= '0;
            dispense_q <= 1'b0;
            disp_sel_q <= 2'd0;
            change_q   <= 3'b000;
            reject_q   <= 1'b0;
            funds_q    <= 1'b0;
            sold_q     <= 1'b0;
            sold_out_q <= 4'b0000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            stock_q    <= stock_d;
            cnt_q      <= cnt_d;
            dispense_q <= dispense_d;
            disp_sel_q <= disp_sel_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
            funds_q    <= funds_d;
            sold_q     <= sold_d;
            sold_out_q <= sold_out_d;
            busy_q     <= busy_d;
        end
    end

    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign disp_sel    = disp_sel_q;
    assign change_25   = change_q[2];
    assign change_10   = change_q[1];
    assign change_5    = change_q[0];
    assign coin_reject = reject_q;
    assign err_funds   = funds_q;
    assign err_sold    = sold_q;
    assign sold_out    = sold_out_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboarded bench for vend_controller: stimulus queues expected output events, a monitor checks them.
module tb_vend_controller;

    localparam logic [7:0] E_RISE = 8'h80;
    localparam logic [7:0] E_FALL = 8'h40;
    localparam logic [7:0] E_C25  = 8'h20;
    localparam logic [7:0] E_C10  = 8'h10;
    localparam logic [7:0] E_C5   = 8'h08;
    localparam logic [7:0] E_REJ  = 8'h04;
    localparam logic [7:0] E_FUND = 8'h02;
    localparam logic [7:0] E_SOLD = 8'h01;

    typedef struct {
        string      name;
        logic [7:0] ev;
        logic [7:0] credit;
        logic       busy;
        logic [3:0] sold;
        logic [1:0] dsel;
        int         len;
    } exp_t;

    logic       clk, rst;
    logic       coin_5, coin_10, coin_25, buy, cancel;
    logic [1:0] sel;
    logic [7:0] credit;
    logic       dispense, change_5, change_10, change_25;
    logic       coin_reject, err_funds, err_sold, busy;
    logic [1:0] disp_sel;
    logic [3:0] sold_out;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    vend_controller dut (
        .clk         (clk),
        .rst         (rst),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .coin_25     (coin_25),
        .buy         (buy),
        .sel         (sel),
        .cancel      (cancel),
        .credit      (credit),
        .dispense    (dispense),
        .disp_sel    (disp_sel),
        .change_5    (change_5),
        .change_10   (change_10),
        .change_25   (change_25),
        .coin_reject (coin_reject),
        .err_funds   (err_funds),
        .err_sold    (err_sold),
        .sold_out    (sold_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input string n, input logic [7:0] ev, input logic [7:0] cr,
                        input logic b, input logic [3:0] so, input logic [1:0] ds, input int len);
        exp_t e;
        e.name = n; e.ev = ev; e.credit = cr; e.busy = b; e.sold = so; e.dsel = ds; e.len = len;
        q.push_back(e);
    endtask

    task automatic drive(input logic c5, input logic c10, input logic c25, input logic b,
                         input logic [1:0] s, input logic cn);
        coin_5 = c5; coin_10 = c10; coin_25 = c25; buy = b; sel = s; cancel = cn;
        @(posedge clk);
        #1;
        coin_5 = 0; coin_10 = 0; coin_25 = 0; buy = 0; sel = 2'd0; cancel = 0;
    endtask

    task automatic coin(input int v);
        drive(v == 5, v == 10, v == 25, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: any pulse or dispense edge is an output event and consumes one expected entry
    logic [7:0] mon_ev;
    logic       prev_disp;
    int         run;
    exp_t       me;
    initial begin
        prev_disp = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            mon_ev = {dispense & ~prev_disp, ~dispense & prev_disp, change_25, change_10,
                      change_5, coin_reject, err_funds, err_sold};
            if (dispense) run++;
            if (mon_ev != 8'h00) begin
                if (q.size() == 0) begin
                    check("unexpected_event", {24'h0, mon_ev}, 32'h0);
                end else begin
                    me = q.pop_front();
                    check(me.name, {9'h0, mon_ev, credit, busy, sold_out, disp_sel},
                          {9'h0, me.ev, me.credit, me.busy, me.sold, me.dsel});
                    if (me.ev[6]) check({me.name, "_len"}, run, me.len);
                end
            end
            if (!dispense) run = 0;
            prev_disp = dispense;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] so;
        rst = 1'b0;
        coin_5 = 0; coin_10 = 0; coin_25 = 0; buy = 0; sel = 2'd0; cancel = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {credit, dispense, disp_sel, change_5, change_10, change_25,
                                coin_reject, err_funds, err_sold, sold_out, busy}, 32'h0);
        rst = 1'b1;
        wait_cyc(1);

        // Buy product 1 with 50, expect 10 back after a 4-cycle dispense
        coin(25); coin(25);
        check("t1_credit50", credit, 50);
        push("t1_rise", E_RISE, 10, 1, 4'b0000, 2'd1, 0);
        push("t1_end", E_FALL | E_C10, 0, 0, 4'b0000, 2'd1, 4);
        drive(0, 0, 0, 1, 2'd1, 0);
        check("t1_credit10", credit, 10);
        wait_cyc(6);
        check("t1_idle", {credit, busy}, 0);

        // Ceiling rejection then full refund
        repeat (4) coin(25);
        check("t2_credit100", credit, 100);
        push("t2_reject", E_REJ, 100, 0, 4'b0000, 2'd1, 0);
        coin(5);
        check("t2_still100", credit, 100);
        push("t2_chg1", E_C25, 75, 1, 4'b0000, 2'd1, 0);
        push("t2_chg2", E_C25, 50, 1, 4'b0000, 2'd1, 0);
        push("t2_chg3", E_C25, 25, 1, 4'b0000, 2'd1, 0);
        push("t2_chg4", E_C25, 0, 0, 4'b0000, 2'd1, 0);
        drive(0, 0, 0, 0, 2'd0, 1);
        wait_cyc(5);
        check("t2_credit0", credit, 0);

        // Insufficient funds
        coin(25); coin(5);
        push("t3_funds", E_FUND, 30, 0, 4'b0000, 2'd1, 0);
        drive(0, 0, 0, 1, 2'd2, 0);
        check("t3_credit30", {credit, busy}, {8'd30, 1'b0});
        push("t3_chg1", E_C25, 5, 1, 4'b0000, 2'd1, 0);
        push("t3_chg2", E_C5, 0, 0, 4'b0000, 2'd1, 0);
        drive(0, 0, 0, 0, 2'd0, 1);
        wait_cyc(3);

        // Sell out product 0
        for (int k = 0; k < 3; k++) begin
            so = (k == 2) ? 4'b0001 : 4'b0000;
            coin(25);
            push("t4_rise", E_RISE, 0, 1, so, 2'd0, 0);
            push("t4_fall", E_FALL, 0, 0, so, 2'd0, 4);
            drive(0, 0, 0, 1, 2'd0, 0);
            wait_cyc(5);
        end
        check("t4_sold_out", sold_out, 4'b0001);
        coin(25);
        push("t4_err_sold", E_SOLD, 25, 0, 4'b0001, 2'd0, 0);
        drive(0, 0, 0, 1, 2'd0, 0);
        check("t4_credit25", credit, 25);
        push("t4_refund", E_C25, 0, 0, 4'b0001, 2'd0, 0);
        drive(0, 0, 0, 0, 2'd0, 1);
        wait_cyc(2);

        // Two coins at once: rejected from 70, accepted from 60
        coin(25); coin(25); coin(10); coin(10);
        check("t5_credit70", credit, 70);
        push("t5_reject", E_REJ, 70, 0, 4'b0001, 2'd0, 0);
        drive(0, 1, 1, 0, 2'd0, 0);
        check("t5_still70", credit, 70);
        push("t5_a1", E_C25, 45, 1, 4'b0001, 2'd0, 0);
        push("t5_a2", E_C25, 20, 1, 4'b0001, 2'd0, 0);
        push("t5_a3", E_C10, 10, 1, 4'b0001, 2'd0, 0);
        push("t5_a4", E_C10, 0, 0, 4'b0001, 2'd0, 0);
        drive(0, 0, 0, 0, 2'd0, 1);
        wait_cyc(5);
        coin(25); coin(25); coin(10);
        drive(0, 1, 1, 0, 2'd0, 0);
        check("t5_credit95", credit, 95);
        push("t5_b1", E_C25, 70, 1, 4'b0001, 2'd0, 0);
        push("t5_b2", E_C25, 45, 1, 4'b0001, 2'd0, 0);
        push("t5_b3", E_C25, 20, 1, 4'b0001, 2'd0, 0);
        push("t5_b4", E_C10, 10, 1, 4'b0001, 2'd0, 0);
        push("t5_b5", E_C10, 0, 0, 4'b0001, 2'd0, 0);
        drive(0, 0, 0, 0, 2'd0, 1);
        wait_cyc(6);

        // Reset in the middle of paying out 15
        coin(10); coin(5);
        check("t6_credit15", credit, 15);
        drive(0, 0, 0, 0, 2'd0, 1);
        check("t6_in_change", {change_10, credit, busy}, {1'b1, 8'd5, 1'b1});
        rst = 1'b0;
        #1;
        check("t6_reset_outputs", {credit, dispense, disp_sel, change_5, change_10, change_25,
                                   coin_reject, err_funds, err_sold, sold_out, busy}, 32'h0);
        wait_cyc(1);
        rst = 1'b1;
        wait_cyc(1);

        // Stock restored: product 0 sells again and stays in stock
        coin(25);
        push("t7_rise", E_RISE, 0, 1, 4'b0000, 2'd0, 0);
        push("t7_fall", E_FALL, 0, 0, 4'b0000, 2'd0, 4);
        drive(0, 0, 0, 1, 2'd0, 0);
        wait_cyc(6);

        check("leftover_expected", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
